mmu: RTL and testbench
======================

Name: mmu

Overview:
- Memory/MMIO unit directly downstream of the two-stage RV32I core.
- Serves instruction fetches on a read-only port and FD-stage loads/stores on a read/write port, both into one dual-port block RAM.
- Decodes a small MMIO window: 64-bit machine timer (mtime/mtimecmp) and an 8-bit GPIO.
- Drives the core's irq_mtimecmp input.

Parameters:
- RAM_WORDS, 1024, depth of unified RAM in 32-bit words (power of 2; byte span 4*RAM_WORDS from 0x00000000).
- MMIO_BASE, 32'h80000000, base of the MMIO window (16 words).
- TIMER_DIV, 1, clk cycles per mtime increment (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- im_addr  in  32  fetch address (core nextPC, combinational)
- im_do  out  32  fetched instruction, registered, valid the cycle after im_addr
- dm_addr  in  32  load/store byte address
- dm_di  in  32  store data, right-aligned
- dm_we  in  1  store strobe
- dm_be  in  4  lane byte enables, already positioned by dm_addr[1:0]; 0000 = no access
- dm_is_signed  in  1  sign-extend loaded byte/half
- dm_do  out  32  load data, right-aligned and extended, valid the cycle after the request
- irq_mtimecmp  out  1  timer interrupt level
- gpio_in  in  8  input pins
- gpio_out  out  8  output register

Behaviour:
- Reset values:
  - im_do = 32'h00000013 (NOP).
  - dm_do = 0.
  - mtime = 0.
  - mtimecmp = all ones.
  - irq_mtimecmp = 0.
  - gpio_out = 0.
  - Divider counter = 0.
  - RAM contents are not reset and are retained across reset mid-operation.
- Fetch:
  - im_do <= RAM[im_addr[log2(4*RAM_WORDS)-1:2]] when im_addr < 4*RAM_WORDS; otherwise 0 (core raises illegal instruction).
  - im_addr[1:0] is ignored.
  - Latency is 1 cycle, every cycle, with no stall.
- Data port address decode:
  - RAM when dm_addr < 4*RAM_WORDS.
  - MMIO when dm_addr[31:6] == MMIO_BASE[31:6].
  - Anything else is unmapped: reads return 0, writes are dropped.
- Store:
  - Store occurs when dm_we && dm_be != 0.
  - Lane data = dm_di << (8*dm_addr[1:0]).
  - The RAM byte write applies only the enabled lanes at the clock edge.
  - Legal dm_be patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other pattern: store is dropped, load returns 0.
- Load:
  - The request registers be, is_signed and the region.
  - Next cycle, dm_do extracts:
    - byte lane k → bits[7:0];
    - half lane 0/2 → bits[15:0];
    - word → bits[31:0].
  - Extension is sign or zero according to the registered is_signed.
  - If be == 0, dm_do = 0.
  - dm_do updates only on cycles with a load request and holds otherwise.
- Read-during-write on the same RAM word: the data port returns the old data; the fetch port returns the old data.
- MMIO word map (offset from MMIO_BASE, word accesses only; sub-word MMIO accesses are dropped or read as 0):
  - 0x00: mtime[31:0]
  - 0x04: mtime[63:32]
  - 0x08: mtimecmp[31:0]
  - 0x0C: mtimecmp[63:32]
  - 0x10: gpio_out (R/W, bits 7:0)
  - 0x14: gpio_in (RO, synchronised through two flops)
- Timer:
  - The divider counts 0..TIMER_DIV-1. mtime increments by 1 when the divider wraps.
  - mtime wraps from 2^64-1 to 0.
  - A software write to either mtime half in the same cycle as an increment: the written half takes the written value, and the other half does not take a carry that cycle.
- Interrupt:
  - irq_mtimecmp <= (mtime >= mtimecmp), unsigned 64-bit compare of the current register values, registered.
  - The level holds until mtimecmp is raised above mtime or mtime wraps.
- No FSM beyond the divider and the one-cycle response pipelines. Both ports accept a request every cycle.

Decomposition:
- Shared header mmu_map.vh holds:
  - MMIO offsets (MMIO_MTIME_LO/HI, MMIO_MTIMECMP_LO/HI, MMIO_GPIO_OUT, MMIO_GPIO_IN);
  - NOP encoding;
  - legal byte-enable patterns.
- One sub-module: dual_port_ram, with one synchronous read port, one synchronous read port with byte-write, and RAM_WORDS depth, inferable as iCE40 EBR.
- Load alignment/extension and MMIO decode stay inline.

Test Plan:
- Reset: hold reset 3 cycles with a prior fetch in flight → im_do = 32'h00000013, dm_do = 0, irq_mtimecmp = 0, gpio_out = 0; RAM word 0 is unchanged after release.
- Store/load sizes:
  - Sequence: sw 0x80FF7F01 @0x100; lb @0x103 (signed); lbu @0x103; lh @0x102 (signed); lhu @0x100; lw @0x100.
  - Required results, each 1 cycle after its request: 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x00007F01, 0x80FF7F01.
- Byte store: sb dm_di = 0x000000AA @0x101 after the word above → lw @0x100 = 0x80FFAA01.
- Illegal access:
  - be = 0110 store → memory unchanged.
  - Access @0x40000000 → dm_do = 0.
  - im_addr = 0x40000000 → im_do = 0.
- Timer (TIMER_DIV = 1):
  - Write mtimecmp hi = 0, then lo = 20 → irq rises on the first edge after mtime reaches 20, without the prior sampled value being ≥ 20.
  - Then write mtimecmp hi = 1 → irq falls 1 cycle later.
- Timer collision and rollover:
  - Write mtime lo = 0xFFFFFFFF on the same cycle as an increment → mtime = {old_hi, 0xFFFFFFFF}.
  - Next increment → hi = old_hi + 1, lo = 0.
- GPIO: write 0x5A to gpio_out → pin = 0x5A next cycle; gpio_in = 0x3C → read returns 0x3C after 2-cycle synchronisation.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared definitions for the memory/MMIO unit: MMIO word map, NOP encoding,
// legal byte-enable patterns and the response region tag.
package mmu_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // MMIO word indices (byte offset from MMIO_BASE divided by 4)
  localparam logic [3:0] MMIO_MTIME_LO    = 4'h0;
  localparam logic [3:0] MMIO_MTIME_HI    = 4'h1;
  localparam logic [3:0] MMIO_MTIMECMP_LO = 4'h2;
  localparam logic [3:0] MMIO_MTIMECMP_HI = 4'h3;
  localparam logic [3:0] MMIO_GPIO_OUT    = 4'h4;
  localparam logic [3:0] MMIO_GPIO_IN     = 4'h5;

  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_RAM  = 2'd1,
    REG_MMIO = 2'd2
  } region_t;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_WORD: be_legal = 1'b1;
      default:                                         be_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mmu_dual_port_ram.sv
// Unified instruction/data RAM: one read-only port and one read/byte-write
// port, both synchronous with read-old-data on collision (EBR friendly).
module dual_port_ram #(
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(WORDS)-1:0] a_addr,
  output logic [31:0]              a_do,
  input  logic [$clog2(WORDS)-1:0] b_addr,
  input  logic [3:0]               b_we,
  input  logic [31:0]              b_di,
  output logic [31:0]              b_do
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    a_do <= mem[a_addr];
    b_do <= mem[b_addr];
    for (int i = 0; i < 4; i++) begin
      if (b_we[i]) mem[b_addr][8*i +: 8] <= b_di[8*i +: 8];
    end
  end

endmodule

// File: rtl/mmu.sv
// Memory/MMIO unit behind the RV32I core: fetch port, load/store port,
// machine timer with compare interrupt, and an 8-bit GPIO.
module mmu
  import mmu_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          TIMER_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] im_addr,
  output logic [31:0] im_do,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_di,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic        dm_is_signed,
  output logic [31:0] dm_do,
  output logic        irq_mtimecmp,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0] ram_a_do, ram_b_do;
  logic [3:0]  ram_we;
  logic [31:0] lane_data;
  logic        dm_in_ram, dm_in_mmio, mmio_wr, load_req;
  logic [3:0]  mmio_off;
  logic [31:0] mmio_rdata;

  logic        im_nop_q, im_ok_q;
  logic        load_q, sgn_q;
  logic [3:0]  be_q;
  region_t     region_q;
  logic [31:0] mmio_q, dm_hold, raw, ext;

  logic [63:0] mtime, mtimecmp, mtime_inc;
  logic [31:0] div_cnt;
  logic        tick;
  logic [7:0]  gpio_s1, gpio_s2;

  assign dm_in_ram  = dm_addr < RAM_BYTES;
  assign dm_in_mmio = dm_addr[31:6] == MMIO_BASE[31:6];
  assign mmio_off   = dm_addr[5:2];
  assign mmio_wr    = dm_we && dm_in_mmio && (dm_be == BE_WORD);
  assign load_req   = !dm_we && (dm_be != 4'b0000);
  assign lane_data  = dm_di << {dm_addr[1:0], 3'b000};
  assign ram_we     = (dm_we && dm_in_ram && be_legal(dm_be)) ? dm_be : 4'b0000;

  dual_port_ram #(.WORDS(RAM_WORDS)) u_ram (
    .clk    (clk),
    .a_addr (im_addr[AW+1:2]),
    .a_do   (ram_a_do),
    .b_addr (dm_addr[AW+1:2]),
    .b_we   (ram_we),
    .b_di   (lane_data),
    .b_do   (ram_b_do)
  );

  // The RAM output register cannot be reset, so the NOP and out-of-range
  // cases are overlaid from small flags registered alongside the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_nop_q <= 1'b1;
      im_ok_q  <= 1'b0;
    end else begin
      im_nop_q <= 1'b0;
      im_ok_q  <= im_addr < RAM_BYTES;
    end
  end

  assign im_do = im_nop_q ? NOP : (im_ok_q ? ram_a_do : 32'h0);

  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_off)
      MMIO_MTIME_LO:    mmio_rdata = mtime[31:0];
      MMIO_MTIME_HI:    mmio_rdata = mtime[63:32];
      MMIO_MTIMECMP_LO: mmio_rdata = mtimecmp[31:0];
      MMIO_MTIMECMP_HI: mmio_rdata = mtimecmp[63:32];
      MMIO_GPIO_OUT:    mmio_rdata = {24'h0, gpio_out};
      MMIO_GPIO_IN:     mmio_rdata = {24'h0, gpio_s2};
      default:          mmio_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_q   <= 1'b0;
      be_q     <= 4'b0000;
      sgn_q    <= 1'b0;
      region_q <= REG_NONE;
      mmio_q   <= 32'h0;
      dm_hold  <= 32'h0;
    end else begin
      load_q   <= load_req;
      be_q     <= dm_be;
      sgn_q    <= dm_is_signed;
      region_q <= dm_in_ram ? REG_RAM : (dm_in_mmio ? REG_MMIO : REG_NONE);
      mmio_q   <= mmio_rdata;
      dm_hold  <= dm_do;
    end
  end

  // Lane extraction; sub-word MMIO reads and unmapped regions yield zero.
  always_comb begin
    raw = 32'h0;
    if (region_q == REG_RAM) raw = ram_b_do;
    else if (region_q == REG_MMIO && be_q == BE_WORD) raw = mmio_q;
    ext = 32'h0;
    case (be_q)
      BE_B0:   ext = {{24{sgn_q & raw[7]}},  raw[7:0]};
      BE_B1:   ext = {{24{sgn_q & raw[15]}}, raw[15:8]};
      BE_B2:   ext = {{24{sgn_q & raw[23]}}, raw[23:16]};
      BE_B3:   ext = {{24{sgn_q & raw[31]}}, raw[31:24]};
      BE_H0:   ext = {{16{sgn_q & raw[15]}}, raw[15:0]};
      BE_H1:   ext = {{16{sgn_q & raw[31]}}, raw[31:16]};
      BE_WORD: ext = raw;
      default: ext = 32'h0;
    endcase
  end

  assign dm_do = load_q ? ext : dm_hold;

  assign tick      = div_cnt == 32'(TIMER_DIV - 1);
  assign mtime_inc = mtime + 64'd1;

  // A software write to one mtime half wins over the increment; writing the
  // low half also suppresses the carry into the high half for that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= 32'h0;
      mtime        <= 64'h0;
      mtimecmp     <= '1;
      irq_mtimecmp <= 1'b0;
      gpio_out     <= 8'h0;
      gpio_s1      <= 8'h0;
      gpio_s2      <= 8'h0;
    end else begin
      div_cnt <= tick ? 32'h0 : div_cnt + 32'h1;
      if (mmio_wr && mmio_off == MMIO_MTIME_LO) mtime[31:0] <= dm_di;
      else if (tick) mtime[31:0] <= mtime_inc[31:0];
      if (mmio_wr && mmio_off == MMIO_MTIME_HI) mtime[63:32] <= dm_di;
      else if (tick && !(mmio_wr && mmio_off == MMIO_MTIME_LO)) mtime[63:32] <= mtime_inc[63:32];
      if (mmio_wr && mmio_off == MMIO_MTIMECMP_LO) mtimecmp[31:0] <= dm_di;
      if (mmio_wr && mmio_off == MMIO_MTIMECMP_HI) mtimecmp[63:32] <= dm_di;
      if (mmio_wr && mmio_off == MMIO_GPIO_OUT) gpio_out <= dm_di[7:0];
      irq_mtimecmp <= mtime >= mtimecmp;
      gpio_s1      <= gpio_in;
      gpio_s2      <= gpio_s1;
    end
  end

endmodule

// File: tb/tb_mmu.sv
// Directed testbench for mmu: reset, fetch, load/store sizes, illegal
// accesses, timer compare/collision and GPIO.
module tb_mmu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] im_addr, im_do;
  logic [31:0] dm_addr, dm_di, dm_do;
  logic        dm_we, dm_is_signed;
  logic [3:0]  dm_be;
  logic        irq_mtimecmp;
  logic [7:0]  gpio_in, gpio_out;

  int totalCount = 0;
  int badCount   = 0;
  int cyc        = 0;

  mmu dut (
    .clk          (clk),
    .reset        (reset),
    .im_addr      (im_addr),
    .im_do        (im_do),
    .dm_addr      (dm_addr),
    .dm_di        (dm_di),
    .dm_we        (dm_we),
    .dm_be        (dm_be),
    .dm_is_signed (dm_is_signed),
    .dm_do        (dm_do),
    .irq_mtimecmp (irq_mtimecmp),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out)
  );

  always #5 clk = ~clk;

  // Edges since reset release; with TIMER_DIV=1 this equals mtime.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] di,
                               input logic we, input logic [3:0] be, input logic sgn);
    @(negedge clk);
    dm_addr      = addr;
    dm_di        = di;
    dm_we        = we;
    dm_be        = be;
    dm_is_signed = sgn;
    @(posedge clk);
    #1;
    dm_we = 1'b0;
    dm_be = 4'b0000;
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; im_addr = 32'h0; dm_addr = 32'h0; dm_di = 32'h0;
    dm_we = 1'b0; dm_be = 4'b0000; dm_is_signed = 1'b0; gpio_in = 8'h00;
    applyReset(2);
    @(negedge clk) reset = 1'b0;

    // Preload word 0, set GPIO and leave a nonzero load result before reset
    applyStimulus(32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 4'b1111, 1'b0);
    @(posedge clk); #1;
    checkOutput("fetch_word0", im_do, 32'hDEAD_BEEF);
    applyStimulus(32'h8000_0010, 32'h0000_005A, 1'b1, 4'b1111, 1'b0);
    applyStimulus(32'h0000_0000, 32'h0, 1'b0, 4'b1111, 1'b0);
    checkOutput("lw_word0", dm_do, 32'hDEAD_BEEF);

    applyReset(3);
    checkOutput("rst_im_do", im_do, 32'h0000_0013);
    checkOutput("rst_dm_do", dm_do, 32'h0);
    checkOutput("rst_irq", {31'b0, irq_mtimecmp}, 32'h0);
    checkOutput("rst_gpio_out", {24'b0, gpio_out}, 32'h0);
    @(negedge clk) reset = 1'b0;
    applyStimulus(32'h0000_0000, 32'h0, 1'b0, 4'b1111, 1'b0);
    checkOutput("ram_kept", dm_do, 32'hDEAD_BEEF);
    checkOutput("fetch_after_rst", im_do, 32'hDEAD_BEEF);

    // Timer compare: mtime equals cyc, so irq first sets after edge 21
    applyStimulus(32'h8000_000C, 32'h0, 1'b1, 4'b1111, 1'b0);
    applyStimulus(32'h8000_0008, 32'd20, 1'b1, 4'b1111, 1'b0);
    while (cyc < 26) begin
      @(posedge clk); #1;
      checkOutput($sformatf("irq_rise_c%0d", cyc), {31'b0, irq_mtimecmp}, 32'(cyc >= 21));
    end
    applyStimulus(32'h8000_000C, 32'h1, 1'b1, 4'b1111, 1'b0);
    checkOutput("irq_hold", {31'b0, irq_mtimecmp}, 32'h1);
    @(posedge clk); #1;
    checkOutput("irq_fall", {31'b0, irq_mtimecmp}, 32'h0);

    // Collision of a low-half write with an increment, then rollover
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'b1111, 1'b0);
    applyStimulus(32'h8000_0000, 32'h0, 1'b0, 4'b1111, 1'b0);
    checkOutput("mtime_lo_wr", dm_do, 32'hFFFF_FFFF);
    applyStimulus(32'h8000_0004, 32'h0, 1'b0, 4'b1111, 1'b0);
    checkOutput("mtime_hi_carry", dm_do, 32'h1);
    applyStimulus(32'h8000_0000, 32'h0, 1'b0, 4'b1111, 1'b0);
    checkOutput("mtime_lo_wrapped", dm_do, 32'h1);

    // Fetch port returns old data when the same word is stored that cycle
    applyStimulus(32'h0000_0100, 32'h1111_1111, 1'b1, 4'b1111, 1'b0);
    im_addr = 32'h0000_0100;
    applyStimulus(32'h0000_0100, 32'h80FF_7F01, 1'b1, 4'b1111, 1'b0);
    checkOutput("fetch_rdw_old", im_do, 32'h1111_1111);
    @(posedge clk); #1;
    checkOutput("fetch_new", im_do, 32'h80FF_7F01);

    applyStimulus(32'h0000_0103, 32'h0, 1'b0, 4'b1000, 1'b1);
    checkOutput("lb", dm_do, 32'hFFFF_FF80);
    applyStimulus(32'h0000_0103, 32'h0, 1'b0, 4'b1000, 1'b0);
    checkOutput("lbu", dm_do, 32'h0000_0080);
    applyStimulus(32'h0000_0102, 32'h0, 1'b0, 4'b1100, 1'b1);
    checkOutput("lh", dm_do, 32'hFFFF_80FF);
    applyStimulus(32'h0000_0100, 32'h0, 1'b0, 4'b0011, 1'b0);
    checkOutput("lhu", dm_do, 32'h0000_7F01);
    applyStimulus(32'h0000_0100, 32'h0, 1'b0, 4'b1111, 1'b0);
    checkOutput("lw", dm_do, 32'h80FF_7F01);

    applyStimulus(32'h0000_0101, 32'h0000_00AA, 1'b1, 4'b0010, 1'b0);
    applyStimulus(32'h0000_0100, 32'h0, 1'b0, 4'b1111, 1'b0);
    checkOutput("sb_merge", dm_do, 32'h80FF_AA01);

    applyStimulus(32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 4'b0110, 1'b0);
    applyStimulus(32'h0000_0100, 32'h0, 1'b0, 4'b1111, 1'b0);
    checkOutput("illegal_be_store", dm_do, 32'h80FF_AA01);
    @(posedge clk); #1;
    checkOutput("dm_do_hold", dm_do, 32'h80FF_AA01);
    applyStimulus(32'h4000_0000, 32'h0, 1'b0, 4'b1111, 1'b0);
    checkOutput("unmapped_load", dm_do, 32'h0);
    applyStimulus(32'h0000_0100, 32'h0, 1'b0, 4'b1111, 1'b0);
    applyStimulus(32'h0000_0100, 32'h0, 1'b0, 4'b0110, 1'b0);
    checkOutput("illegal_be_load", dm_do, 32'h0);

    im_addr = 32'h4000_0000;
    @(posedge clk); #1;
    checkOutput("fetch_unmapped", im_do, 32'h0);

    applyStimulus(32'h8000_0010, 32'h0000_00A5, 1'b1, 4'b1111, 1'b0);
    checkOutput("gpio_out_a5", {24'b0, gpio_out}, 32'h0000_00A5);
    applyStimulus(32'h8000_0010, 32'h0000_005A, 1'b1, 4'b1111, 1'b0);
    checkOutput("gpio_out_5a", {24'b0, gpio_out}, 32'h0000_005A);
    @(negedge clk) gpio_in = 8'h3C;
    repeat (2) @(posedge clk);
    applyStimulus(32'h8000_0014, 32'h0, 1'b0, 4'b1111, 1'b0);
    checkOutput("gpio_in_sync", dm_do, 32'h0000_003C);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
